// File: rtl/ex_stage_pipe.sv
// Handshaked execute stage: ALU, compare/branch, NZCV register and a registered output slot.
// Optional iterative shift-add multiplier for op 14 is built when EX_MUL_EN is defined.
module ex_stage_pipe #(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    op,
    input  logic          src_sel,
    input  logic          imm_sel,
    input  logic          set_cond,
    input  logic [DW-1:0] data_a,
    input  logic [DW-1:0] data_b,
    input  logic [DW-1:0] alu_imm,
    input  logic [DW-1:0] ls_imm,
    input  logic [DW-1:0] br_imm,
    input  logic [DW-1:0] pc,
    input  logic [RW-1:0] rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] alu_result,
    output logic [DW-1:0] new_pc,
    output logic [DW-1:0] imm_out,
    output logic [RW-1:0] rd_out,
    output logic          branch_taken,
    output logic [3:0]    cond_out,
    output logic          busy
);
    localparam int unsigned SW = $clog2(DW);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_BEQ   = 4'd10;
    localparam logic [3:0] OP_BNE   = 4'd11;
    localparam logic [3:0] OP_BLT   = 4'd12;
    localparam logic [3:0] OP_BGE   = 4'd13;
    localparam logic [3:0] OP_MUL   = 4'd14;
    localparam logic [3:0] OP_PASSB = 4'd15;

    logic          accept;
    logic [DW-1:0] b_op;
    logic [SW-1:0] shamt;

    assign in_ready = ~busy & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign b_op     = src_sel ? (imm_sel ? ls_imm : alu_imm) : data_b;
    assign shamt    = b_op[SW-1:0];

    // Single-cycle ALU, branch compare and flag generation
    logic [DW:0]   add_full;
    logic [DW:0]   sub_full;
    logic [DW-1:0] alu_c;
    logic          br_c;
    logic          carry_c;
    logic          ovf_c;
    logic          slt_c;
    logic          sltu_c;

    always_comb begin
        add_full = {1'b0, data_a} + {1'b0, b_op};
        sub_full = {1'b0, data_a} - {1'b0, b_op};
        slt_c    = $signed(data_a) < $signed(b_op);
        sltu_c   = data_a < b_op;
        alu_c    = '0;
        br_c     = 1'b0;
        carry_c  = 1'b0;
        ovf_c    = 1'b0;
        case (op)
            OP_ADD: begin
                alu_c   = add_full[DW-1:0];
                carry_c = add_full[DW];
                ovf_c   = (data_a[DW-1] == b_op[DW-1]) && (add_full[DW-1] != data_a[DW-1]);
            end
            OP_SUB: begin
                alu_c   = sub_full[DW-1:0];
                carry_c = ~sub_full[DW];
                ovf_c   = (data_a[DW-1] != b_op[DW-1]) && (sub_full[DW-1] != data_a[DW-1]);
            end
            OP_AND:   alu_c = data_a & b_op;
            OP_OR:    alu_c = data_a | b_op;
            OP_XOR:   alu_c = data_a ^ b_op;
            OP_SLL:   alu_c = data_a << shamt;
            OP_SRL:   alu_c = data_a >> shamt;
            OP_SRA:   alu_c = $unsigned($signed(data_a) >>> shamt);
            OP_SLT:   alu_c = {{(DW-1){1'b0}}, slt_c};
            OP_SLTU:  alu_c = {{(DW-1){1'b0}}, sltu_c};
            OP_BEQ:   br_c  = (data_a == b_op);
            OP_BNE:   br_c  = (data_a != b_op);
            OP_BLT:   br_c  = slt_c;
            OP_BGE:   br_c  = ~slt_c;
            OP_PASSB: alu_c = b_op;
            default:  alu_c = '0;
        endcase
    end

    logic          mul_done;
    logic [DW-1:0] mul_res;
    logic [DW-1:0] mul_npc;
    logic [DW-1:0] mul_imm;
    logic [RW-1:0] mul_rd;
    logic          mul_set;

`ifdef EX_MUL_EN
    localparam bit MUL_EN = 1'b1;

    typedef enum logic {S_IDLE, S_MUL} state_t;
    state_t        state;
    state_t        state_nx;
    logic          mul_start;
    logic [SW-1:0] count;
    logic [DW-1:0] mcand;
    logic [DW-1:0] mplier;
    logic [DW-1:0] acc;

    assign busy    = (state == S_MUL);
    assign mul_res = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept && op == OP_MUL) state_nx = S_MUL;
            S_MUL:   if (count == SW'(DW - 1))   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        mul_start = 1'b0;
        mul_done  = 1'b0;
        case (state)
            S_IDLE:  mul_start = accept && (op == OP_MUL);
            S_MUL:   mul_done  = (count == SW'(DW - 1));
            default: ;
        endcase
    end

    // Shift-add datapath: one multiplier bit consumed per busy cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            mul_npc <= '0;
            mul_imm <= '0;
            mul_rd  <= '0;
            mul_set <= 1'b0;
        end else if (mul_start) begin
            count   <= '0;
            mcand   <= data_a;
            mplier  <= b_op;
            acc     <= '0;
            mul_npc <= pc + br_imm;
            mul_imm <= br_imm;
            mul_rd  <= rd;
            mul_set <= set_cond;
        end else if (busy) begin
            count  <= count + SW'(1);
            acc    <= mul_res;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end
`else
    localparam bit MUL_EN = 1'b0;

    assign busy     = 1'b0;
    assign mul_done = 1'b0;
    assign mul_res  = '0;
    assign mul_npc  = '0;
    assign mul_imm  = '0;
    assign mul_rd   = '0;
    assign mul_set  = 1'b0;
`endif

    logic alu_load;
    logic flag_ok;

    assign alu_load = accept & ~(MUL_EN & (op == OP_MUL));
    assign flag_ok  = set_cond & (op != OP_MUL);

    // Output slot and NZCV register; a load wins over a same-edge drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            alu_result   <= '0;
            new_pc       <= '0;
            imm_out      <= '0;
            rd_out       <= '0;
            branch_taken <= 1'b0;
            cond_out     <= 4'b0000;
        end else if (mul_done) begin
            out_valid    <= 1'b1;
            alu_result   <= mul_res;
            new_pc       <= mul_npc;
            imm_out      <= mul_imm;
            rd_out       <= mul_rd;
            branch_taken <= 1'b0;
            if (mul_set) cond_out <= {mul_res[DW-1], mul_res == '0, 2'b00};
        end else if (alu_load) begin
            out_valid    <= 1'b1;
            alu_result   <= alu_c;
            new_pc       <= pc + br_imm;
            imm_out      <= br_imm;
            rd_out       <= rd;
            branch_taken <= br_c;
            if (flag_ok) cond_out <= {alu_c[DW-1], alu_c == '0, carry_c, ovf_c};
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end
    end
endmodule

// File: doc/ex_stage_pipe.md
# ex_stage_pipe

Parametrised, handshaked execute stage that replaces the fixed-width, always-advancing execute latch. It sits between decode and memory and takes decoded operands, immediates, PC and destination register under valid/ready flow control. It performs ALU, compare-and-branch and (optionally) iterative multiply operations, and keeps an NZCV condition register. Results are presented in a single registered output slot that holds under back-pressure.

## Interface
Parameters:
- DW, 32, datapath width; power of two, at least 8.
- RW, 6, destination register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  decode presents an operation.
- in_ready  out  1  stage accepts the operation this cycle.
- op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 MUL, 15 PASSB.
- src_sel  in  1  operand B source: 0 = data_b, 1 = selected immediate.
- imm_sel  in  1  immediate select: 0 = alu_imm, 1 = ls_imm.
- set_cond  in  1  update NZCV from this operation.
- data_a, data_b  in  DW  register operands.
- alu_imm, ls_imm, br_imm  in  DW  sign-extended immediates.
- pc  in  DW  PC of the operation.
- rd  in  RW  destination register.
- out_valid  out  1  output slot holds a result.
- out_ready  in  1  memory stage takes the result.
- alu_result  out  DW  operation result.
- new_pc  out  DW  branch target.
- imm_out  out  DW  br_imm passed through.
- rd_out  out  RW  rd passed through.
- branch_taken  out  1  branch condition true.
- cond_out  out  4  NZCV register {N,Z,C,V}.
- busy  out  1  multiply in progress.

## Operation
- Accept = in_valid & in_ready. `in_ready = ~busy & (~out_valid | out_ready)`.
- Operand B = src_sel ? (imm_sel ? ls_imm : alu_imm) : data_b.
- Arithmetic is mod 2^DW.
- Shift ops use B[log2(DW)-1:0] only.
- SLT is signed and SLTU is unsigned; each yields 1 or 0.
- BEQ/BNE/BLT/BGE: BLT and BGE compare signed; alu_result = 0 and branch_taken = the comparison result. branch_taken = 0 for all non-branch ops.
- new_pc = pc + br_imm (mod 2^DW), computed for every op.
- MUL: low DW bits of A*B, computed by an iterative shift-add, one multiplier bit per cycle.
- Flags, computed from alu_result:
  - N = result[DW-1].
  - Z = (result == 0).
  - C = carry-out on ADD; C = NOT borrow on SUB; C = 0 otherwise.
  - V = signed overflow on ADD/SUB; V = 0 otherwise.
- The NZCV register updates when the output slot loads and the op carried set_cond = 1. Otherwise it holds.
- FSM:
  - IDLE: on accept of MUL, go to MUL with count = 0. Any other accepted op loads the output slot at that edge.
  - MUL: one iteration per cycle with busy = 1. When count reaches DW-1, load the output slot and return to IDLE.
- The output slot loads on completion and clears when out_valid & out_ready and nothing loads that edge. Load and drain on the same edge leave the slot full with the new result.
- While out_valid & ~out_ready, all outputs hold stable.

## Timing
- Reset values: out_valid 0; in_ready 1 once reset is released; busy 0; alu_result, new_pc, imm_out 0; rd_out 0; branch_taken 0; cond_out 4'b0000; FSM IDLE.
- Non-MUL latency: out_valid is high the cycle after the accept edge.
- Throughput is 1 op/cycle when out_ready stays high.
- MUL latency: out_valid rises DW cycles after the accept edge. in_ready is 0 throughout.
- A MUL is accepted only when the slot is empty or draining, so the slot is empty for the whole multiply.
- Reset mid-multiply abandons the multiply with no output. Reset with a full slot drops the result.
- Only flops and in_ready have combinational paths. in_ready depends on out_ready combinationally. No other input-to-output combinational path exists.

## Configuration
- EX_MUL_EN:
  - Defined: op 14 runs the iterative multiply above.
  - Undefined: the multiplier and MUL state are not built and busy is tied to 0. Op 14 completes in one cycle with alu_result = 0 and branch_taken = 0, and NZCV is not updated even with set_cond = 1.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 with set_cond=1 -> alu_result 0x80000000, cond_out 4'b1001 the next cycle.
- SUB 5-5 with set_cond=1 -> result 0, cond_out 4'b0110. A following ADD 1+1 with set_cond=0 -> result 2, cond_out stays 4'b0110.
- BEQ with data_a = data_b = 3, pc 0x100, br_imm 0x20 -> branch_taken 1, new_pc 0x120. BNE with the same operands -> branch_taken 0, new_pc 0x120.
- Back-pressure: out_ready=0 while ADD 1+2 then OR 0xF0|0x0F are issued -> out_valid 1 with result 3 held, and in_ready 0 after the first accept. Raising out_ready -> 3 then 0xFF delivered in order, with no loss or duplication.
- MUL 12345 * 1000 (EX_MUL_EN) -> busy 1 and in_ready 0 for 32 cycles, then alu_result 0x00BC5EA8 with out_valid 1.
  - Repeat with rst pulsed at cycle 10 -> out_valid 0, busy 0, cond_out 0, and no result is ever emitted.
- Without EX_MUL_EN: op 14 with set_cond=1 -> result 0 after 1 cycle, cond_out unchanged, busy never 1.
